pixel_stream_sched: RTL and testbench
=====================================

# pixel_stream_sched

Frame scheduler that sequences the raster pixel path: issues (x, y) coordinate requests to a one-cycle-latency colour source, captures returned colours in a 3-entry buffer, and presents them downstream as a valid/ready stream with start-of-frame, end-of-line and end-of-frame flags. It sits between the frame-control logic (start/abort/continuous) and the video-output stream, and absorbs downstream backpressure without dropping or duplicating pixels.

## Interface
- DATA_WIDTH, 10, coordinate width
- RBG_SIZE, 24, colour width
- SCREEN_WIDTH, 640, pixels per line
- SCREEN_HEIGHT, 480, lines per frame
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- start  in  1  begin a frame; honoured only in IDLE
- continuous  in  1  when 1 at the last pixel, wrap directly into the next frame
- abort  in  1  synchronous; discard everything and return to IDLE
- req_valid  out  1  coordinate request issued this cycle
- req_x, req_y  out  DATA_WIDTH  requested coordinate
- colour_i  in  RBG_SIZE  colour for the coordinate requested in the previous cycle
- out_valid  out  1  buffer head valid
- out_ready  in  1  downstream accepts head
- colour_o  out  RBG_SIZE  head colour
- sof, eol, eof  out  1 each  head flags; 0 whenever out_valid=0
- busy  out  1  state != IDLE
- frame_count  out  16  frames fully delivered, wraps at 2^16

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on start; req_x=req_y=0.
- RUN: req_valid = (fifo_count + inflight) < 3, computed from registered values; inflight = req_valid of previous cycle. No credit is taken for a same-cycle pop.
- On each issue, the coordinate advances: x+1; at x=SCREEN_WIDTH-1, x=0 and y+1. Flags are computed at issue and delayed one cycle alongside inflight: sof = (0,0), eol = (x==SCREEN_WIDTH-1), eof = last pixel (eol also set).
- Issue of the last pixel (SCREEN_WIDTH-1, SCREEN_HEIGHT-1):
  - continuous=1 (sampled in that cycle): coordinates wrap to (0,0) and state stays RUN.
  - continuous=0: -> DRAIN.
- DRAIN: no issues; -> IDLE when fifo_count==0 and inflight==0.
- In-flight colour and flags are written to the FIFO in the cycle after issue. Pop when out_valid && out_ready. Simultaneous push and pop leaves the count unchanged. The 3-entry depth gives 1 pixel/clk with out_ready=1; the issue rule makes overflow impossible.
- frame_count increments on acceptance of an eof beat, not on issue.
- start outside IDLE: ignored. Changing continuous mid-frame affects only the next wrap decision.
- abort (any state, priority over start): FIFO flushed, inflight discarded, coordinates (0,0), -> IDLE next cycle. frame_count is held.
- Reset values: state IDLE, all outputs 0, fifo_count 0, frame_count 0. Reset mid-frame has the same effect as abort, and also clears frame_count.

## Timing
- start high in cycle s (IDLE): busy=1 and req_valid=1 with (0,0) in s+1; colour_i sampled in s+2; out_valid=1 with sof in s+3.
- Pixel latency from request to head: 2 cycles.
- out_ready held 1: one beat per cycle, no bubbles, including across continuous frame wraps.
- out_ready low for N cycles: at most 3 beats buffered and req_valid=0 while occupancy is 3. On out_ready rising, the stream resumes with no gap.
- Last beat of a non-continuous frame accepted in cycle e: busy=0 in e+1, frame_count updated in e+1.
- colour_o and flags are stable while out_valid && !out_ready.

## Test plan
- W=4, H=3, out_ready=1, start pulse: 12 beats in 12 consecutive cycles starting at s+3; sof on beat 0 only; eol on beats 3, 7, 11; eof on beat 11; frame_count=1; busy=0 after.
- Same setup, out_ready toggling 1,0,0,1 pattern: colours match a coordinate-derived source (colour=y*4+x); no loss or duplication; FIFO count never exceeds 3; head held stable while stalled.
- continuous=1 for 3 frames, then dropped mid-frame 4: 48 gap-free beats; sof on beats 0, 12, 24, 36; frame_count=4; then IDLE.
- abort at beat 5 with 2 entries buffered: out_valid=0 next cycle; IDLE; frame_count unchanged; next start restarts at (0,0) with sof.
- start pulsed during RUN, and start coincident with abort: both ignored; no coordinate reset; stream unaffected.
- Async reset asserted mid-frame between clock edges: all outputs 0 immediately; frame_count=0; a clean frame follows after release.

Source files
------------

// File: rtl/pixel_stream_sched.sv
// pixel_stream_sched
// Raster pixel scheduler. Walks (x, y) over the frame, issues one coordinate
// request per cycle to a colour source that answers one cycle later, parks the
// answers in a 3-entry buffer and presents them as a valid/ready stream.
//
// Ports
//   clk, reset           clock; asynchronous active-high reset
//   start                begin a frame (only honoured when idle)
//   continuous           at the last pixel of a frame, roll straight into the next
//   abort                synchronous flush back to idle
//   req_valid/req_x/y    coordinate request to the colour source
//   colour_i             colour for the coordinate requested one cycle earlier
//   out_valid/out_ready  downstream handshake on the buffer head
//   colour_o, sof/eol/eof  head colour and frame flags (0 when out_valid=0)
//   busy                 not idle
//   frame_count          frames whose eof beat has been accepted (wraps)
//
// state | meaning
// IDLE  | waiting for start, nothing buffered or in flight
// RUN   | issuing coordinates while buffer + in-flight < 3
// DRAIN | last pixel issued, waiting for buffer and in-flight to empty

module pixel_stream_sched #(
    parameter int DATA_WIDTH    = 10,
    parameter int RBG_SIZE      = 24,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  abort,
    output logic                  req_valid,
    output logic [DATA_WIDTH-1:0] req_x,
    output logic [DATA_WIDTH-1:0] req_y,
    input  logic [RBG_SIZE-1:0]   colour_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RBG_SIZE-1:0]   colour_o,
    output logic                  sof,
    output logic                  eol,
    output logic                  eof,
    output logic                  busy,
    output logic [15:0]           frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Buffer entry layout: {eof, eol, sof, colour}
    localparam int ENTRY_W = RBG_SIZE + 3;
    localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(SCREEN_HEIGHT - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic [DATA_WIDTH-1:0] y_q, y_d;
    logic                  infl_q, infl_d;
    logic [2:0]            infl_flags_q, infl_flags_d;
    logic [ENTRY_W-1:0]    mem_q [3];
    logic [ENTRY_W-1:0]    mem_d [3];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic [15:0]           frame_count_q, frame_count_d;

    logic [2:0]            occupancy;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  fifo_valid;
    logic [ENTRY_W-1:0]    head;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        infl_d        = 1'b0;
        infl_flags_d  = 3'b000;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        frame_count_d = frame_count_q;

        // Credit check uses registered values only; a pop in this same cycle
        // does not free a slot until the next cycle.
        occupancy  = {1'b0, count_q} + {2'b00, infl_q};
        issue      = (state_q == ST_RUN) && (occupancy < 3'd3);
        fifo_valid = (count_q != 2'd0);
        head       = mem_q[rd_ptr_q];
        push       = infl_q;
        pop        = fifo_valid && out_ready;

        if (push) begin
            mem_d[wr_ptr_q] = {infl_flags_q, colour_i};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            if (head[ENTRY_W-1]) begin
                frame_count_d = frame_count_q + 16'd1;
            end
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end

        if (issue) begin
            infl_d       = 1'b1;
            infl_flags_d = {(x_q == X_LAST) && (y_q == Y_LAST),
                            (x_q == X_LAST),
                            (x_q == '0) && (y_q == '0)};
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d = '0;
                    if (!continuous) begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ST_RUN: begin
            end
            ST_DRAIN: begin
                // Look at next-cycle occupancy so busy drops the cycle right
                // after the final beat is accepted.
                if ((count_d == 2'd0) && !infl_d) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d       = ST_IDLE;
            x_d           = '0;
            y_d           = '0;
            infl_d        = 1'b0;
            infl_flags_d  = 3'b000;
            wr_ptr_d      = 2'd0;
            rd_ptr_d      = 2'd0;
            count_d       = 2'd0;
            frame_count_d = frame_count_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            infl_q        <= 1'b0;
            infl_flags_q  <= 3'b000;
            wr_ptr_q      <= 2'd0;
            rd_ptr_q      <= 2'd0;
            count_q       <= 2'd0;
            frame_count_q <= 16'd0;
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            infl_q        <= infl_d;
            infl_flags_q  <= infl_flags_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            frame_count_q <= frame_count_d;
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign req_valid   = issue;
    assign req_x       = x_q;
    assign req_y       = y_q;
    assign out_valid   = fifo_valid;
    assign colour_o    = fifo_valid ? head[RBG_SIZE-1:0] : '0;
    assign eof         = fifo_valid & head[ENTRY_W-1];
    assign eol         = fifo_valid & head[ENTRY_W-2];
    assign sof         = fifo_valid & head[ENTRY_W-3];
    assign busy        = (state_q != ST_IDLE);
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_stream_sched.sv
// Bench for pixel_stream_sched on a 4x3 screen. The colour source answers
// each request with y*4+x one cycle later, so the n-th beat of a frame must
// carry colour n. A negedge monitor holds the reference model: the expected
// beat index, expected next request coordinate, issued/accepted counts and
// the expected frame count.

module tb_pixel_stream_sched;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 10;
    localparam int CW = 24;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          continuous;
    logic          abort;
    logic          out_ready;
    logic [CW-1:0] colour_i;
    logic          req_valid;
    logic [DW-1:0] req_x;
    logic [DW-1:0] req_y;
    logic          out_valid;
    logic [CW-1:0] colour_o;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          busy;
    logic [15:0]   frame_count;

    int vectors = 0;
    int miscompares = 0;

    int          exp_p = 0;
    int          rx = 0;
    int          ry = 0;
    int          issued = 0;
    int          accepted = 0;
    logic [15:0] exp_frames = 16'd0;
    logic        prev_stall = 1'b0;
    logic [27:0] prev_head = '0;

    pixel_stream_sched #(
        .DATA_WIDTH   (DW),
        .RBG_SIZE     (CW),
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .start      (start),
        .continuous (continuous),
        .abort      (abort),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .colour_i   (colour_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .colour_o   (colour_o),
        .sof        (sof),
        .eol        (eol),
        .eof        (eof),
        .busy       (busy),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // One-cycle-latency colour source
    always @(posedge clk) begin
        colour_i <= CW'(int'(req_y) * W + int'(req_x));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_p      = 0;
            rx         = 0;
            ry         = 0;
            issued     = 0;
            accepted   = 0;
            exp_frames = 16'd0;
            prev_stall = 1'b0;
        end else begin
            chk("frame_count", 32'(frame_count), 32'(exp_frames));
            if (!out_valid) begin
                chk("idle_flags", 32'({sof, eol, eof}), 32'(0));
            end
            if (prev_stall) begin
                chk("stall_hold", 32'({out_valid, sof, eol, eof, colour_o}), 32'(prev_head));
            end
            if (req_valid) begin
                chk("req_x", 32'(req_x), 32'(rx));
                chk("req_y", 32'(req_y), 32'(ry));
                issued++;
                rx++;
                if (rx == W) begin
                    rx = 0;
                    ry++;
                    if (ry == H) ry = 0;
                end
            end
            chk("occupancy", 32'((issued - accepted) <= 3), 32'(1));
            if (out_valid && out_ready) begin
                chk("colour", 32'(colour_o), 32'(exp_p));
                chk("flags", 32'({sof, eol, eof}),
                    32'({exp_p == 0, (exp_p % W) == W - 1, exp_p == NPIX - 1}));
                accepted++;
                if (exp_p == NPIX - 1) exp_frames = exp_frames + 16'd1;
                exp_p = (exp_p + 1) % NPIX;
            end
            prev_stall = out_valid && !out_ready && !abort;
            prev_head  = {out_valid, sof, eol, eof, colour_o};
            if (abort) begin
                exp_p      = 0;
                rx         = 0;
                ry         = 0;
                issued     = 0;
                accepted   = 0;
                prev_stall = 1'b0;
            end
        end
    end

    task automatic chk_quiet(input string tag);
        chk(tag, 32'({req_valid, out_valid, sof, eol, eof, busy}), 32'(0));
        chk({tag, "_colour"}, 32'(colour_o), 32'(0));
        chk({tag, "_req_xy"}, 32'({req_x, req_y}), 32'(0));
    endtask

    // mode 0: ready held high; 1: ready pattern 1,0,0,1; 2: random ready with
    // spurious start pulses while the frame is mid-way.
    task automatic run_frame(input int mode);
        logic [3:0] pat;
        logic       done;
        pat  = 4'b1001;
        done = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            case (mode)
                1: out_ready = pat[i % 4];
                2: begin
                    out_ready = 1'($urandom_range(0, 1));
                    start = (exp_p > 0) && (exp_p < 8) && ($urandom_range(0, 3) == 0);
                end
                default: out_ready = 1'b1;
            endcase
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("frame_done", 32'(done), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        rst = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk_quiet("rst_outs");
        chk("rst_frames", 32'(frame_count), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Single frame, ready high: exact latency and gap-free 12 beats
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        chk("t1_busy_s", 32'(busy), 32'(0));
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("t1_req_s1", 32'({busy, req_valid, req_x, req_y}), 32'({2'b11, 20'd0}));
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_nohead_s2", 32'(out_valid), 32'(0));
        for (int i = 0; i < NPIX; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("t1_gapfree", 32'(out_valid), 32'(1));
            chk("t1_sof", 32'(sof), 32'(i == 0));
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_idle_after", 32'({busy, out_valid}), 32'(0));
        chk("t1_frames", 32'(frame_count), 32'(1));

        // Backpressure pattern
        run_frame(1);
        chk("t2_frames", 32'(frame_count), 32'(2));

        // Continuous: three full frames then drop continuous during frame 4
        continuous = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4 * NPIX; i++) begin
            @(posedge clk); #1;
            if (i == 41) continuous = 1'b0;
            @(negedge clk);
            chk("t3_gapfree", 32'(out_valid), 32'(1));
            chk("t3_sof", 32'(sof), 32'((i % NPIX) == 0));
        end
        continuous = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_idle_after", 32'(busy), 32'(0));
        chk("t3_frames", 32'(frame_count), 32'(6));

        // Abort with the head stalled and two entries buffered
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) got++;
            if (got == 5) break;
            @(posedge clk); #1;
        end
        chk("t4_reach", 32'(got), 32'(5));
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t4_stalled", 32'(out_valid), 32'(1));
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_flushed", 32'({out_valid, busy}), 32'(0));
        chk("t4_frames", 32'(frame_count), 32'(6));
        run_frame(0);
        chk("t4_restart_frames", 32'(frame_count), 32'(7));

        // Random backpressure with start pulses during RUN
        run_frame(2);
        chk("t5_frames", 32'(frame_count), 32'(8));

        // start coincident with abort: abort wins, no restart
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("t6_aborted", 32'({out_valid, busy}), 32'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_stays_idle", 32'({busy, req_valid}), 32'(0));
        chk("t6_frames", 32'(frame_count), 32'(8));

        // Asynchronous reset between clock edges, mid-frame
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_quiet("t7_rst_now");
        chk("t7_rst_frames", 32'(frame_count), 32'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_frame(0);
        chk("t7_frames", 32'(frame_count), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
